// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen: LCD raster timing generator in the pixel-clock domain.
// Raster timing is held off until the PLL lock flag has been synchronized
// and has stayed high for LOCK_SETTLE consecutive clocks.
//
// Ports:
//   clock        pixel clock (PLL output)
//   reset_n      asynchronous active-low reset
//   locked       PLL lock flag, asynchronous to clock
//   hsync        horizontal sync, active level HS_POL
//   vsync        vertical sync, active level VS_POL
//   de           data enable, high during active pixels
//   x, y         active pixel column/row, 0 when de is low
//   frame_start  one-clock pulse with de at x=0, y=0
//   running      high while the FSM is in RUN
//   rgb          RGB565 colour-bar test pattern, aligned with de
//                (present only when LCD_TIMING_PATTERN_EN is defined)
//
// Optional feature macro: LCD_TIMING_PATTERN_EN
//
// state     | meaning
// ----------+-----------------------------------------------------------
// WAIT_LOCK | raster idle, waiting for synchronized lock
// SETTLE    | lock seen, counting LOCK_SETTLE clocks of continuous lock
// RUN       | raster counters advancing, outputs driven from (hc, vc)

module lcd_timing_gen #(
  parameter int   H_ACTIVE    = 480,
  parameter int   H_FP        = 8,
  parameter int   H_SYNC      = 4,
  parameter int   H_BP        = 43,
  parameter int   V_ACTIVE    = 272,
  parameter int   V_FP        = 4,
  parameter int   V_SYNC      = 4,
  parameter int   V_BP        = 12,
  parameter logic HS_POL      = 1'b0,
  parameter logic VS_POL      = 1'b0,
  parameter int   LOCK_SETTLE = 1024,
  parameter int   XW          = 10,
  parameter int   YW          = 10
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          locked,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          frame_start,
  output logic          running
`ifdef LCD_TIMING_PATTERN_EN
  ,
  output logic [15:0]   rgb
`endif
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int SW       = (LOCK_SETTLE > 1) ? $clog2(LOCK_SETTLE) : 1;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic          lk_m, lk_s;
  logic [SW-1:0] settle_cnt;
  logic          settle_done;
  logic          settle_adv;
  logic          run_adv;
  logic [XW-1:0] hc;
  logic [YW-1:0] vc;

  logic          de_d, hs_act, vs_act, fs_d;
  logic [XW-1:0] x_d;
  logic [YW-1:0] y_d;

  // Two-flop synchronizer for the asynchronous lock flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lk_m <= 1'b0;
      lk_s <= 1'b0;
    end else begin
      lk_m <= locked;
      lk_s <= lk_m;
    end
  end

  assign settle_done = (settle_cnt == SW'(LOCK_SETTLE - 1));

  // FSM: state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= WAIT_LOCK;
    else          state <= state_nxt;
  end

  // FSM: next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_LOCK: if (lk_s) state_nxt = SETTLE;
      SETTLE: begin
        if (!lk_s)            state_nxt = WAIT_LOCK;
        else if (settle_done) state_nxt = RUN;
      end
      RUN:     if (!lk_s) state_nxt = WAIT_LOCK;
      default: state_nxt = WAIT_LOCK;
    endcase
  end

  // FSM: outputs. run_adv is false on the clock lock is lost, so the
  // counters and registered outputs return to reset values on that edge.
  always_comb begin
    running    = (state == RUN);
    run_adv    = (state == RUN) && lk_s;
    settle_adv = (state == SETTLE) && lk_s && !settle_done;
  end

  // Settle counter: cleared whenever lock qualification is broken, and
  // also on the RUN transition so a later relock starts from zero.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)        settle_cnt <= '0;
    else if (settle_adv) settle_cnt <= settle_cnt + 1'b1;
    else                 settle_cnt <= '0;
  end

  // Raster counters. They sit at zero outside RUN, so the first RUN clock
  // always presents hc = 0, vc = 0.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hc <= '0;
      vc <= '0;
    end else if (run_adv) begin
      if (hc == XW'(H_TOTAL - 1)) begin
        hc <= '0;
        if (vc == YW'(V_TOTAL - 1)) vc <= '0;
        else                        vc <= vc + 1'b1;
      end else begin
        hc <= hc + 1'b1;
      end
    end else begin
      hc <= '0;
      vc <= '0;
    end
  end

  // Decode of the current counter value; registered below.
  always_comb begin
    de_d   = run_adv && (hc < XW'(H_ACTIVE)) && (vc < YW'(V_ACTIVE));
    hs_act = run_adv && (hc >= XW'(HS_START)) && (hc < XW'(HS_END));
    vs_act = run_adv && (vc >= YW'(VS_START)) && (vc < YW'(VS_END));
    fs_d   = run_adv && (hc == '0) && (vc == '0);
    x_d    = de_d ? hc : '0;
    y_d    = de_d ? vc : '0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= hs_act ? HS_POL : ~HS_POL;
      vsync       <= vs_act ? VS_POL : ~VS_POL;
      de          <= de_d;
      x           <= x_d;
      y           <= y_d;
      frame_start <= fs_d;
    end
  end

`ifdef LCD_TIMING_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;

  logic [2:0]  bar;
  logic [15:0] bar_rgb;

  // Bar index by threshold compare instead of a divider.
  always_comb begin
    bar = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (hc >= XW'(i * BAR_W)) bar = 3'(i);
    end
  end

  always_comb begin
    bar_rgb = 16'h0000;
    case (bar)
      3'd0: bar_rgb = 16'hFFFF;  // white
      3'd1: bar_rgb = 16'hFFE0;  // yellow
      3'd2: bar_rgb = 16'h07FF;  // cyan
      3'd3: bar_rgb = 16'h07E0;  // green
      3'd4: bar_rgb = 16'hF81F;  // magenta
      3'd5: bar_rgb = 16'hF800;  // red
      3'd6: bar_rgb = 16'h001F;  // blue
      3'd7: bar_rgb = 16'h0000;  // black
      default: bar_rgb = 16'h0000;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rgb <= 16'h0000;
    else          rgb <= de_d ? bar_rgb : 16'h0000;
  end
`endif

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Testbench for lcd_timing_gen with a reduced raster so full frames fit in
// a short run. The reference model works from elapsed clocks of qualified
// lock: the raster position is plain arithmetic on that count.

module tb_lcd_timing_gen;

  localparam int HA = 32, HF = 3, HS = 4, HB = 5;
  localparam int VA = 5,  VF = 2, VS = 3, VB = 2;
  localparam int LS = 24;
  localparam int XW = 10, YW = 10;
  localparam int HT = HA + HF + HS + HB;   // 44
  localparam int VT = VA + VF + VS + VB;   // 12
  localparam int FR = HT * VT;             // 528

  logic          clock   = 1'b0;
  logic          reset_n = 1'b0;
  logic          locked  = 1'b0;
  logic          hsync, vsync, de, frame_start, running;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
`ifdef LCD_TIMING_PATTERN_EN
  logic [15:0]   rgb;
`endif

  lcd_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .LOCK_SETTLE(LS), .XW(XW), .YW(YW)
  ) dut (
    .clock(clock), .reset_n(reset_n), .locked(locked),
    .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
    .frame_start(frame_start), .running(running)
`ifdef LCD_TIMING_PATTERN_EN
    , .rgb(rgb)
`endif
  );

  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  // run_len = consecutive clocks on which the synchronized lock was high.
  // RUN holds once run_len reaches LS+1; outputs lag the counters by one.
  int          run_len = 0;
  logic        lk_d1 = 1'b0, lk_d2 = 1'b0;
  logic        e_hs, e_vs, e_de, e_fs, e_run;
  int          e_x, e_y;
  logic [15:0] e_rgb;
  logic [15:0] bars [8];

  initial begin
    bars[0] = 16'hFFFF; bars[1] = 16'hFFE0; bars[2] = 16'h07FF; bars[3] = 16'h07E0;
    bars[4] = 16'hF81F; bars[5] = 16'hF800; bars[6] = 16'h001F; bars[7] = 16'h0000;
  end

  always @(posedge clock) begin
    int p, hc, vc;
    if (!reset_n) begin
      lk_d1 = 1'b0; lk_d2 = 1'b0; run_len = 0;
    end else begin
      if (lk_d2) run_len++;
      else       run_len = 0;
      lk_d2 = lk_d1;
      lk_d1 = locked;
    end
    e_run = (run_len >= LS + 1);
    e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_fs = 1'b0; e_x = 0; e_y = 0; e_rgb = 16'h0;
    if (run_len >= LS + 2) begin
      p  = (run_len - (LS + 2)) % FR;
      hc = p % HT;
      vc = p / HT;
      e_de = (hc < HA) && (vc < VA);
      e_x  = e_de ? hc : 0;
      e_y  = e_de ? vc : 0;
      e_hs = !((hc >= HA + HF) && (hc < HA + HF + HS));
      e_vs = !((vc >= VA + VF) && (vc < VA + VF + VS));
      e_fs = (p == 0);
      e_rgb = e_de ? bars[hc / (HA / 8)] : 16'h0;
    end
  end

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int edge_n  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, got, exp);
    end
  endtask

  function automatic logic [31:0] pack(input logic hs, input logic vs, input logic d,
                                       input logic fs, input logic rn, input int xv, input int yv);
    logic [9:0] xs, ys;
    xs = 10'(xv);
    ys = 10'(yv);
    return {7'd0, hs, vs, d, fs, rn, xs, ys};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
    edge_n++;
    chk("model", pack(hsync, vsync, de, frame_start, running, int'(x), int'(y)),
                 pack(e_hs, e_vs, e_de, e_fs, e_run, e_x, e_y));
`ifdef LCD_TIMING_PATTERN_EN
    chk("model_rgb", {16'h0, rgb}, {16'h0, e_rgb});
`endif
  endtask

  typedef struct {
    int   p;
    logic de;
    int   xv;
    int   yv;
    logic hs;
    logic vs;
    logic fs;
  } vec_t;

  vec_t vt [15];

  initial begin
    int mark, budget;
    logic seen;

    // p = clocks after the first frame_start of an undisturbed run
    vt[0]  = '{0,   1'b1, 0,  0, 1'b1, 1'b1, 1'b1};
    vt[1]  = '{31,  1'b1, 31, 0, 1'b1, 1'b1, 1'b0};
    vt[2]  = '{32,  1'b0, 0,  0, 1'b1, 1'b1, 1'b0};
    vt[3]  = '{34,  1'b0, 0,  0, 1'b1, 1'b1, 1'b0};
    vt[4]  = '{35,  1'b0, 0,  0, 1'b0, 1'b1, 1'b0};
    vt[5]  = '{38,  1'b0, 0,  0, 1'b0, 1'b1, 1'b0};
    vt[6]  = '{39,  1'b0, 0,  0, 1'b1, 1'b1, 1'b0};
    vt[7]  = '{49,  1'b1, 5,  1, 1'b1, 1'b1, 1'b0};
    vt[8]  = '{207, 1'b1, 31, 4, 1'b1, 1'b1, 1'b0};
    vt[9]  = '{220, 1'b0, 0,  0, 1'b1, 1'b1, 1'b0};
    vt[10] = '{308, 1'b0, 0,  0, 1'b1, 1'b0, 1'b0};
    vt[11] = '{344, 1'b0, 0,  0, 1'b0, 1'b0, 1'b0};
    vt[12] = '{439, 1'b0, 0,  0, 1'b1, 1'b0, 1'b0};
    vt[13] = '{440, 1'b0, 0,  0, 1'b1, 1'b1, 1'b0};
    vt[14] = '{528, 1'b1, 0,  0, 1'b1, 1'b1, 1'b1};

    // Reset with lock already present.
    locked = 1'b1;
    repeat (5) tick();
    chk("reset_state", pack(hsync, vsync, de, frame_start, running, int'(x), int'(y)),
                       pack(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0));
`ifdef LCD_TIMING_PATTERN_EN
    chk("reset_rgb", {16'h0, rgb}, 32'h0);
`endif
    @(negedge clock);
    reset_n = 1'b1;
    edge_n  = 0;

    // running rises exactly 2 + 1 + LS clocks after release.
    while (edge_n < LS + 2) tick();
    chk("run_not_yet", {31'd0, running}, 32'd0);
    tick();
    chk("run_rise", {31'd0, running}, 32'd1);

    // Table of raster points during the first frame and the wrap.
    foreach (vt[i]) begin
      while (edge_n < LS + 3 + 1 + vt[i].p) tick();
      chk($sformatf("vec_p%0d", vt[i].p),
          pack(hsync, vsync, de, frame_start, running, int'(x), int'(y)),
          pack(vt[i].hs, vt[i].vs, vt[i].de, vt[i].fs, 1'b1, vt[i].xv, vt[i].yv));
    end
`ifdef LCD_TIMING_PATTERN_EN
    // Bars are 4 px wide here: x=4 yellow, x=24 blue, x=31 black.
    while (edge_n < LS + 4 + FR + 4) tick();
    chk("rgb_yellow", {16'h0, rgb}, 32'h0000FFE0);
    while (edge_n < LS + 4 + FR + 24) tick();
    chk("rgb_blue", {16'h0, rgb}, 32'h0000001F);
    while (edge_n < LS + 4 + FR + 33) tick();
    chk("rgb_blank", {16'h0, rgb}, 32'h0);
`endif

    // Lock glitch in SETTLE: leave RUN, relock, glitch at settle count 10.
    @(negedge clock); locked = 1'b0;
    repeat (6) tick();
    @(negedge clock); locked = 1'b1;
    mark = edge_n;
    while (edge_n < mark + 13) tick();
    @(negedge clock); locked = 1'b0;
    repeat (3) tick();
    @(negedge clock); locked = 1'b1;
    mark = edge_n;
    seen = 1'b0;
    while (edge_n < mark + LS + 2) begin
      tick();
      seen = seen | de | frame_start | running;
    end
    chk("glitch_no_early", {31'd0, seen}, 32'd0);
    tick();
    chk("glitch_run_rise", {31'd0, running}, 32'd1);
    tick();
    chk("glitch_restart", pack(hsync, vsync, de, frame_start, running, int'(x), int'(y)),
                          pack(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0, 0));

    // Lock loss in RUN at x=20.
    budget = 0;
    while (!(de === 1'b1 && x == 10'd20) && budget < 2 * FR) begin
      tick();
      budget++;
    end
    chk("find_x20", {31'd0, (budget < 2 * FR)}, 32'd1);
    @(negedge clock); locked = 1'b0;
    repeat (2) tick();
    chk("loss_still_run", {31'd0, running}, 32'd1);
    tick();
    chk("loss_stop", pack(hsync, vsync, de, frame_start, running, int'(x), int'(y)),
                     pack(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0));
    repeat (4) tick();
    @(negedge clock); locked = 1'b1;
    mark = edge_n;
    while (edge_n < mark + LS + 3) tick();
    chk("relock_run", {31'd0, running}, 32'd1);
    tick();
    chk("relock_restart", pack(hsync, vsync, de, frame_start, running, int'(x), int'(y)),
                          pack(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0, 0));

    // Randomized lock history checked by the model on every clock.
    for (int s = 0; s < 12; s++) begin
      int hi_len, lo_len;
      hi_len = $urandom_range(900, 0);
      lo_len = $urandom_range(4, 1);
      @(negedge clock); locked = 1'b1;
      repeat (hi_len) tick();
      @(negedge clock); locked = 1'b0;
      repeat (lo_len) tick();
    end
    @(negedge clock); locked = 1'b1;
    repeat (LS + 100) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lcd_timing_gen.md
Name: lcd_timing_gen

Overview:
Generates LCD raster timing: HSYNC, VSYNC, DE, pixel X/Y and a frame-start strobe. It runs in the pixel-clock domain driven by the PLL output (~19.125 MHz from a 12 MHz board clock). It sits directly downstream of the PLL and consumes its clock and lock flag. Raster timing is held off until the PLL lock has been qualified. Downstream pixel sources (framebuffer, waterfall renderer) key off X/Y/DE.

Parameters:
H_ACTIVE, 480, visible pixels per line
H_FP, 8, horizontal front porch (clocks)
H_SYNC, 4, HSYNC width (clocks)
H_BP, 43, horizontal back porch (clocks)
V_ACTIVE, 272, visible lines per frame
V_FP, 4, vertical front porch (lines)
V_SYNC, 4, VSYNC width (lines)
V_BP, 12, vertical back porch (lines)
HS_POL, 0, HSYNC active level (0 = active-low)
VS_POL, 0, VSYNC active level (0 = active-low)
LOCK_SETTLE, 1024, clocks of continuous qualified lock before the raster starts (min 1)
XW, 10, width of x and of the horizontal counter
YW, 10, width of y and of the vertical counter

Ports:
clock  input  1  pixel clock, the PLL output
reset_n  input  1  asynchronous active-low reset
locked  input  1  PLL lock flag; asynchronous to clock
hsync  output  1  horizontal sync, polarity per HS_POL
vsync  output  1  vertical sync, polarity per VS_POL
de  output  1  data enable; high during active pixels
x  output  XW  active pixel column; 0 when de is low
y  output  YW  active pixel row; 0 when de is low
frame_start  output  1  one-clock pulse coincident with de at x=0, y=0
running  output  1  high while the FSM is in RUN

Behaviour:
- Reset is asynchronous and active-low on every flop; single clock domain.
- Reset values: hsync = ~HS_POL, vsync = ~VS_POL, de = 0, x = 0, y = 0, frame_start = 0, running = 0, FSM = WAIT_LOCK, all counters 0.
- locked passes through a 2-flop synchronizer to give lk_s. The synchronizer resets to 0.
- H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP (default 535). V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP (default 292).
- FSM states:
  - WAIT_LOCK: settle counter cleared. Go to SETTLE when lk_s = 1.
  - SETTLE: settle counter increments each clock. If lk_s = 0, return to WAIT_LOCK. When the count reaches LOCK_SETTLE-1 with lk_s = 1, go to RUN and clear hc and vc to 0.
  - RUN: raster counters advance. If lk_s = 0, go to WAIT_LOCK on the next clock. Counters clear, and all outputs return to their reset values on that same clock.
- Counters, RUN only:
  - hc counts 0..H_TOTAL-1, then wraps to 0.
  - vc increments when hc wraps. When vc wraps from V_TOTAL-1, it returns to 0.
- Outputs are registered decodes of (hc, vc), so latency is 1 clock from the counter value.
- All outputs are mutually aligned:
  - de = (hc < H_ACTIVE) && (vc < V_ACTIVE).
  - x = hc and y = vc when de, else 0.
  - hsync is active for H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC, on every line including vertical blanking.
  - vsync is active for V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC, for the whole of each such line.
  - frame_start = (hc == 0) && (vc == 0).
- First RUN clock: hc = 0 and vc = 0, so frame_start and de are both 1 on the next clock.
- Outside RUN: de, frame_start and running are 0, syncs are inactive, x/y are 0.
- Counter widths must hold H_TOTAL-1 and V_TOTAL-1. Out-of-range parameters are unsupported; no run-time checking.

Optional Feature:
LCD_TIMING_PATTERN_EN:
- Defined: adds output rgb [15:0], RGB565, registered and aligned with de.
  - Eight vertical colour bars, each H_ACTIVE/8 wide, in order white, yellow, cyan, green, magenta, red, blue, black.
  - Active colour channels are full scale: R=5'h1F, G=6'h3F, B=5'h1F.
  - rgb = 0 when de = 0 and at reset.
- Not defined: the rgb port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset then lock: reset_n low 5 clocks, locked=1 from the start. Required: running rises exactly 2 (sync) + 1 (WAIT_LOCK) + 1024 (SETTLE) clocks after reset release, ±0. frame_start and de pulse 1 clock later with x=0, y=0.
- Line timing, default params: per line, de high 480 consecutive clocks, x runs 0..479. hsync low for exactly 4 clocks, starting 8 clocks after de falls. Line period = 535 clocks.
- Frame timing: de lines = 272 per frame. vsync low for exactly 4×535 = 2140 clocks, starting 4 lines after the last active line. frame_start period = 535×292 = 156220 clocks.
- Lock glitch in SETTLE: drop locked for 3 clocks at settle count 500. Required: FSM returns to WAIT_LOCK, and the full 1024-clock settle restarts after relock. No de or frame_start appears early.
- Lock loss in RUN: deassert locked mid-line at x=200. Required: 3 clocks later de=0, x=0, running=0, syncs inactive. After relock and settle, the raster restarts at x=0, y=0 with frame_start.
- With LCD_TIMING_PATTERN_EN, use H_ACTIVE=480 so bars are 60 px wide. Required: rgb=16'hFFFF at x=0..59, 16'hFFE0 at x=60, 16'h001F at x=360, 16'h0000 at x=420..479, and 0 during blanking.
